// File: rtl/rv32i_dmem_responder_pkg.sv
// Shared types for the rv32i data-memory responder: access sizes, FSM states
// and the byte-count helper used by the range check.
package rv32i_mem_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC1 = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  // Encoding 3 is illegal and yields zero bytes; callers flag it separately.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      MEM_B:   size_bytes = 3'd1;
      MEM_H:   size_bytes = 3'd2;
      MEM_W:   size_bytes = 3'd4;
      default: size_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_dmem_responder_if.sv
// Load/store request and response channel between the core's LSU (master)
// and the data-memory responder (slave).
interface rv32i_dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_signed, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_signed, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/rv32i_byte_lane_align.sv
// Combinational little-endian lane steering: byte enables and rotated data for
// stores, shift-and-extend of a two-word buffer for loads.
module rv32i_byte_lane_align
  import rv32i_mem_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  input  logic [63:0] rbuf,
  input  logic        is_signed,
  output logic [3:0]  be0,
  output logic [3:0]  be1,
  output logic [31:0] wdata_rot,
  output logic [31:0] rdata
);

  logic [3:0]  lane_mask;
  logic [7:0]  be_wide;
  logic [63:0] wdup;
  logic [63:0] shifted;

  always_comb begin
    case (size)
      MEM_B:   lane_mask = 4'b0001;
      MEM_H:   lane_mask = 4'b0011;
      MEM_W:   lane_mask = 4'b1111;
      default: lane_mask = '0;
    endcase

    // Lanes that spill past bit 3 belong to the following word.
    be_wide   = {4'b0000, lane_mask} << off;
    be0       = be_wide[3:0];
    be1       = be_wide[7:4];

    wdup      = {wdata, wdata} << {off, 3'b000};
    wdata_rot = wdup[63:32];

    shifted   = rbuf >> {off, 3'b000};
    case (size)
      MEM_B:   rdata = {{24{is_signed & shifted[7]}}, shifted[7:0]};
      MEM_H:   rdata = {{16{is_signed & shifted[15]}}, shifted[15:0]};
      MEM_W:   rdata = shifted[31:0];
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/rv32i_dmem_responder.sv
// Byte-addressable data memory for the rv32i load/store port: one request at a
// time, word-crossing accesses split over two cycles, one response per request.
module rv32i_dmem_responder
  import rv32i_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 32768,
  parameter string       INIT_FILE   = ""
) (
  input logic                  clk,
  input logic                  rst_n,
  rv32i_dmem_responder_if.slave bus
);

  localparam int unsigned AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [33:0] LIMIT = {DEPTH_WORDS, 2'b00};

  logic [31:0] mem [DEPTH_WORDS];

  dmem_state_e state_q, state_d;

  logic [AW+1:0] addr_q;
  logic [1:0]    size_q;
  logic          we_q;
  logic          signed_q;
  logic [31:0]   wdata_q;
  logic [31:0]   lo_word_q;
  logic [31:0]   rdata_q;
  logic          err_q;

  logic          accept;
  logic [2:0]    nbytes;
  logic [33:0]   last_addr;
  logic          req_err;
  logic          req_cross;

  logic          in_idle;
  logic [AW-1:0] word_idx;
  logic [31:0]   rd_word;
  logic [1:0]    al_off;
  logic [1:0]    al_size;
  logic [31:0]   al_wdata;
  logic          al_signed;
  logic [63:0]   al_rbuf;
  logic [3:0]    be0, be1, mem_be;
  logic [31:0]   wdata_rot;
  logic [31:0]   al_rdata;
  logic          mem_we;

  // Range check on the live request; 34-bit sum catches 32-bit address wrap.
  always_comb begin
    nbytes    = size_bytes(bus.req_size);
    last_addr = {2'b00, bus.req_addr} + {31'b0, nbytes} - 34'd1;
    req_err   = (bus.req_size == 2'd3) ||
                ({2'b00, bus.req_addr} >= LIMIT) ||
                (last_addr >= LIMIT);
    req_cross = ({1'b0, bus.req_addr[1:0]} + nbytes) > 3'd4;
  end

  assign accept  = bus.req_ready & bus.req_valid;
  assign in_idle = (state_q == IDLE);

  // One aligner and one RAM port serve both cycles: IDLE works on the live
  // request (word 0), ACC1 on the captured one (word 1).
  always_comb begin
    word_idx  = in_idle ? bus.req_addr[AW+1:2] : addr_q[AW+1:2] + AW'(1);
    al_off    = in_idle ? bus.req_addr[1:0]    : addr_q[1:0];
    al_size   = in_idle ? bus.req_size         : size_q;
    al_wdata  = in_idle ? bus.req_wdata        : wdata_q;
    al_signed = in_idle ? bus.req_signed       : signed_q;
  end

  assign rd_word = mem[word_idx];
  assign al_rbuf = in_idle ? {32'b0, rd_word} : {rd_word, lo_word_q};

  rv32i_byte_lane_align u_align (
    .off       (al_off),
    .size      (al_size),
    .wdata     (al_wdata),
    .rbuf      (al_rbuf),
    .is_signed (al_signed),
    .be0       (be0),
    .be1       (be1),
    .wdata_rot (wdata_rot),
    .rdata     (al_rdata)
  );

  assign mem_we = (accept & ~req_err & bus.req_we) | ((state_q == ACC1) & we_q);
  assign mem_be = in_idle ? be0 : be1;

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (mem_we && mem_be[i]) mem[word_idx][8*i +: 8] <= wdata_rot[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (req_cross && !req_err) ? ACC1 : RESP;
      ACC1:    state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = in_idle & rst_n;
    bus.rsp_valid = (state_q == RESP);
    bus.rsp_rdata = rdata_q;
    bus.rsp_err   = err_q;
  end

  // Crossing loads compute a provisional result in IDLE that ACC1 overwrites.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      size_q    <= '0;
      we_q      <= 1'b0;
      signed_q  <= 1'b0;
      wdata_q   <= '0;
      lo_word_q <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else if (accept) begin
      addr_q    <= bus.req_addr[AW+1:0];
      size_q    <= bus.req_size;
      we_q      <= bus.req_we;
      signed_q  <= bus.req_signed;
      wdata_q   <= bus.req_wdata;
      lo_word_q <= rd_word;
      err_q     <= req_err;
      rdata_q   <= (req_err || bus.req_we) ? '0 : al_rdata;
    end else if (state_q == ACC1) begin
      rdata_q   <= we_q ? '0 : al_rdata;
    end
  end

endmodule

// File: tb/tb_rv32i_dmem_responder.sv
// Scoreboard bench for rv32i_dmem_responder: directed loads/stores with
// hand-computed results, latency, back-pressure and mid-access reset.
module tb_rv32i_dmem_responder;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  exp_t sbq[$];
  exp_t e_mon;

  rv32i_dmem_responder_if bus ();

  rv32i_dmem_responder #(
    .DEPTH_WORDS (1024),
    .INIT_FILE   ("")
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Monitor: pops one expectation per response handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
        if (sbq.size() == 0) begin
          n_checks = n_checks + 1;
          $display("FAIL unexpected_rsp: got rdata %h err %b want no response",
                   bus.rsp_rdata, bus.rsp_err);
        end else begin
          e_mon = sbq.pop_front();
          chk({e_mon.name, "_rdata"}, bus.rsp_rdata, e_mon.rdata);
          chk({e_mon.name, "_err"}, {31'b0, bus.rsp_err}, {31'b0, e_mon.err});
        end
      end
    end
  end

  task automatic issue(input string name, input logic we, input logic [31:0] addr,
                       input logic [1:0] size, input logic sgn, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    bit got;
    int lat;
    @(posedge clk); #1;
    bus.req_we     = we;
    bus.req_addr   = addr;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_wdata  = wdata;
    bus.req_valid  = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      chk({name, "_accept"}, 32'd0, 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    sbq.push_back('{rdata: exp_rdata, err: exp_err, name: name});
    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        lat = c;
        break;
      end
    end
    chk({name, "_lat"}, lat, exp_lat);
  endtask

  initial begin
    n_checks       = 0;
    n_pass         = 0;
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_size   = '0;
    bus.req_signed = 1'b0;
    bus.req_wdata  = '0;
    bus.rsp_ready  = 1'b1;

    #3;
    chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_rsp_err",   {31'b0, bus.rsp_err}, 32'd0);
    chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", {31'b0, bus.req_ready}, 32'd1);

    // Aligned word round trip
    issue("sw_100",  1'b1, 32'h100, 2'd2, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 1);
    issue("lw_100",  1'b0, 32'h100, 2'd2, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 1);

    // Word-crossing store then byte/half/word reads across the seam
    issue("sw_103",  1'b1, 32'h103, 2'd2, 1'b0, 32'h11223344, 32'h0, 1'b0, 2);
    issue("lbu_103", 1'b0, 32'h103, 2'd0, 1'b0, 32'h0, 32'h00000044, 1'b0, 1);
    issue("lbu_104", 1'b0, 32'h104, 2'd0, 1'b0, 32'h0, 32'h00000033, 1'b0, 1);
    issue("lbu_105", 1'b0, 32'h105, 2'd0, 1'b0, 32'h0, 32'h00000022, 1'b0, 1);
    issue("lbu_106", 1'b0, 32'h106, 2'd0, 1'b0, 32'h0, 32'h00000011, 1'b0, 1);
    issue("lw_103",  1'b0, 32'h103, 2'd2, 1'b0, 32'h0, 32'h11223344, 1'b0, 2);
    issue("lhu_103", 1'b0, 32'h103, 2'd1, 1'b0, 32'h0, 32'h00003344, 1'b0, 2);
    issue("lw_100b", 1'b0, 32'h100, 2'd2, 1'b0, 32'h0, 32'h44ADBEEF, 1'b0, 1);
    issue("lh_101",  1'b0, 32'h101, 2'd1, 1'b1, 32'h0, 32'hFFFFADBE, 1'b0, 1);

    // Sub-word stores and sign/zero extension
    issue("sw_200",  1'b1, 32'h200, 2'd2, 1'b0, 32'h00000000, 32'h0, 1'b0, 1);
    issue("sb_200",  1'b1, 32'h200, 2'd0, 1'b0, 32'hFFFFFF80, 32'h0, 1'b0, 1);
    issue("lb_200",  1'b0, 32'h200, 2'd0, 1'b1, 32'h0, 32'hFFFFFF80, 1'b0, 1);
    issue("lbu_200", 1'b0, 32'h200, 2'd0, 1'b0, 32'h0, 32'h00000080, 1'b0, 1);
    issue("sh_202",  1'b1, 32'h202, 2'd1, 1'b0, 32'h00008001, 32'h0, 1'b0, 1);
    issue("lh_202",  1'b0, 32'h202, 2'd1, 1'b1, 32'h0, 32'hFFFF8001, 1'b0, 1);
    issue("lhu_202", 1'b0, 32'h202, 2'd1, 1'b0, 32'h0, 32'h00008001, 1'b0, 1);
    issue("lw_200",  1'b0, 32'h200, 2'd2, 1'b0, 32'h0, 32'h80010080, 1'b0, 1);

    // Range limit is 0x1000 bytes; errors return zero data and write nothing
    issue("sw_ffc",   1'b1, 32'hFFC, 2'd2, 1'b0, 32'hCAFEF00D, 32'h0, 1'b0, 1);
    issue("sw_ffe",   1'b1, 32'hFFE, 2'd2, 1'b0, 32'h12345678, 32'h0, 1'b1, 1);
    issue("lw_ffc",   1'b0, 32'hFFC, 2'd2, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0, 1);
    issue("lw_1000",  1'b0, 32'h1000, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1, 1);
    issue("size3",    1'b0, 32'h010, 2'd3, 1'b0, 32'h0, 32'h0, 1'b1, 1);
    issue("lw_wrap",  1'b0, 32'hFFFFFFFE, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1, 1);
    issue("sh_fff",   1'b1, 32'hFFF, 2'd1, 1'b0, 32'h0000BBBB, 32'h0, 1'b1, 1);
    issue("lbu_fff",  1'b0, 32'hFFF, 2'd0, 1'b0, 32'h0, 32'h000000CA, 1'b0, 1);
    issue("lh_ffe",   1'b0, 32'hFFE, 2'd1, 1'b1, 32'h0, 32'hFFFFCAFE, 1'b0, 1);

    // Back-pressure: response held, competing request ignored
    issue("sw_300",  1'b1, 32'h300, 2'd2, 1'b0, 32'h12345678, 32'h0, 1'b0, 1);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    issue("lw_300",  1'b0, 32'h300, 2'd2, 1'b0, 32'h0, 32'h12345678, 1'b0, 1);
    @(posedge clk); #1;
    bus.req_we     = 1'b1;
    bus.req_addr   = 32'h300;
    bus.req_size   = 2'd2;
    bus.req_wdata  = 32'h5555AAAA;
    bus.req_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
      chk("hold_rsp_rdata", bus.rsp_rdata, 32'h12345678);
      chk("hold_req_ready", {31'b0, bus.req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    issue("lw_300b", 1'b0, 32'h300, 2'd2, 1'b0, 32'h0, 32'h12345678, 1'b0, 1);

    // Reset while the second half of a crossing store is pending
    issue("sw_400",  1'b1, 32'h400, 2'd2, 1'b0, 32'h11111111, 32'h0, 1'b0, 1);
    issue("sw_404",  1'b1, 32'h404, 2'd2, 1'b0, 32'h22222222, 32'h0, 1'b0, 1);
    @(posedge clk); #1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h402;
    bus.req_size  = 2'd2;
    bus.req_wdata = 32'hAABBCCDD;
    bus.req_valid = 1'b1;
    @(negedge clk);
    chk("acc1_req_ready", {31'b0, bus.req_ready}, 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("acc1_rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("acc1_rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("acc1_rel_req_ready", {31'b0, bus.req_ready}, 32'd1);
    issue("lw_400",  1'b0, 32'h400, 2'd2, 1'b0, 32'h0, 32'hCCDD1111, 1'b0, 1);
    issue("lw_404",  1'b0, 32'h404, 2'd2, 1'b0, 32'h0, 32'h22222222, 1'b0, 1);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
